// File: rtl/sa_loader.sv
// Frame sequencer for the 4x4 systolic array tile: clears the array, streams weights,
// features and (with SA_LOADER_THRESH_EN) the threshold into it, then runs it once.
module sa_loader #(
  parameter int unsigned RUN_CYCLES = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       busy,
  output logic       done,
  output logic       sa_rst,
  output logic       sa_we,
  output logic       sa_ena,
  output logic [1:0] sa_sel,
  output logic [3:0] sa_addr,
  output logic [7:0] sa_data,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_LOAD_W = 3'd2,
    ST_LOAD_F = 3'd3,
`ifdef SA_LOADER_THRESH_EN
    ST_LOAD_T = 3'd4,
`endif
    ST_RUN    = 3'd5,
    ST_FIN    = 3'd6
  } state_e;

  localparam logic [1:0] SEL_W = 2'b00;
  localparam logic [1:0] SEL_F = 2'b01;
`ifdef SA_LOADER_THRESH_EN
  localparam logic [1:0] SEL_T = 2'b10;
`endif
  localparam logic [7:0] RUN_LOAD = 8'(RUN_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       s_ready_q, s_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sa_rst_q, sa_rst_d;
  logic       sa_we_q, sa_we_d;
  logic       sa_ena_q, sa_ena_d;
  logic [1:0] sa_sel_q, sa_sel_d;
  logic [3:0] sa_addr_q, sa_addr_d;
  logic [7:0] sa_data_q, sa_data_d;
  logic       beat;

  // Handshake: s_ready is registered and only high in the load states; a byte transfers
  // on every rising edge where s_valid && s_ready, and s_data is only sampled on that edge.
  assign beat = s_valid & s_ready_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    s_ready_d = 1'b0;
    done_d    = 1'b0;
    sa_rst_d  = 1'b0;
    sa_we_d   = 1'b0;
    sa_ena_d  = 1'b0;
    sa_sel_d  = sa_sel_q;
    sa_addr_d = sa_addr_q;
    sa_data_d = sa_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_CLR;
          sa_rst_d = 1'b1;
          idx_d    = 4'd0;
        end
      end

      ST_CLR: begin
        state_d   = ST_LOAD_W;
        s_ready_d = 1'b1;
      end

      ST_LOAD_W: begin
        s_ready_d = 1'b1;
        if (beat) begin
          sa_we_d   = 1'b1;
          sa_sel_d  = SEL_W;
          sa_addr_d = idx_q;
          sa_data_d = s_data;
          idx_d     = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = ST_LOAD_F;
          end
        end
      end

      ST_LOAD_F: begin
        s_ready_d = 1'b1;
        if (beat) begin
          sa_we_d   = 1'b1;
          sa_sel_d  = SEL_F;
          sa_addr_d = idx_q;
          sa_data_d = s_data;
          idx_d     = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
`ifdef SA_LOADER_THRESH_EN
            state_d   = ST_LOAD_T;
`else
            // Last byte of the frame: stop accepting and arm the run window.
            state_d   = ST_RUN;
            s_ready_d = 1'b0;
            cnt_d     = RUN_LOAD;
`endif
          end
        end
      end

`ifdef SA_LOADER_THRESH_EN
      ST_LOAD_T: begin
        s_ready_d = 1'b1;
        if (beat) begin
          sa_we_d   = 1'b1;
          sa_sel_d  = SEL_T;
          sa_addr_d = 4'd0;
          sa_data_d = s_data;
          state_d   = ST_RUN;
          s_ready_d = 1'b0;
          cnt_d     = RUN_LOAD;
        end
      end
`endif

      ST_RUN: begin
        // The counter was loaded on entry, so the enable starts the cycle after the last write.
        if (cnt_q != 8'd0) begin
          sa_ena_d = 1'b1;
          cnt_d    = cnt_q - 8'd1;
        end else begin
          done_d  = 1'b1;
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      cnt_q     <= 8'd0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sa_rst_q  <= 1'b1;
      sa_we_q   <= 1'b0;
      sa_ena_q  <= 1'b0;
      sa_sel_q  <= 2'b00;
      sa_addr_q <= 4'd0;
      sa_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sa_rst_q  <= sa_rst_d;
      sa_we_q   <= sa_we_d;
      sa_ena_q  <= sa_ena_d;
      sa_sel_q  <= sa_sel_d;
      sa_addr_q <= sa_addr_d;
      sa_data_q <= sa_data_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sa_rst    = sa_rst_q;
  assign sa_we     = sa_we_q;
  assign sa_ena    = sa_ena_q;
  assign sa_sel    = sa_sel_q;
  assign sa_addr   = sa_addr_q;
  assign sa_data   = sa_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sa_loader.sv
// Self-checking bench for sa_loader: randomized byte streams against a frame-level model,
// with a scoreboard monitor comparing every array write and the run/done timing.
module tb_sa_loader;

  localparam int RUN_CYCLES = 26;
`ifdef SA_LOADER_THRESH_EN
  localparam int FRAME_LEN = 33;
`else
  localparam int FRAME_LEN = 32;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_ready, busy, done, sa_rst, sa_we, sa_ena;
  logic [1:0] sa_sel;
  logic [3:0] sa_addr;
  logic [7:0] sa_data;
  logic [2:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int clr_cycles = 0;
  logic [13:0] exp_q[$];

  sa_loader #(.RUN_CYCLES(RUN_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .busy(busy), .done(done), .sa_rst(sa_rst), .sa_we(sa_we),
    .sa_ena(sa_ena), .sa_sel(sa_sel), .sa_addr(sa_addr), .sa_data(sa_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte k of a frame lands at: 0..15 weights[k], 16..31 features[k-16], 32 threshold.
  function automatic logic [13:0] model_write(input int k, input logic [7:0] d);
    logic [1:0] sel;
    logic [3:0] addr;
    if (k < 16) begin
      sel = 2'b00; addr = 4'(k);
    end else if (k < 32) begin
      sel = 2'b01; addr = 4'(k - 16);
    end else begin
      sel = 2'b10; addr = 4'd0;
    end
    return {sel, addr, d};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int ena_len;
    logic prev_we, prev_ena;
    logic [13:0] last_wr, e;
    ena_len = 0; prev_we = 1'b0; prev_ena = 1'b0; last_wr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ena_len = 0; prev_we = 1'b0; prev_ena = 1'b0; last_wr = '0;
      end else begin
        if (sa_rst) clr_cycles++;
        if (done) done_cnt++;
        if (sa_we || sa_ena) chk("we_ena_exclusive", 32'(sa_we & sa_ena), 32'd0);
        if (sa_we) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'({sa_sel, sa_addr, sa_data}), 32'h3fff_0000);
          end else begin
            e = exp_q.pop_front();
            chk("write", 32'({sa_sel, sa_addr, sa_data}), 32'(e));
          end
          last_wr = {sa_sel, sa_addr, sa_data};
        end else begin
          chk("hold_when_idle", 32'({sa_sel, sa_addr, sa_data}), 32'(last_wr));
        end
        if (sa_ena && !prev_ena) begin
          chk("ena_after_last_we", 32'(prev_we), 32'd1);
          chk("writes_left_at_run", 32'(exp_q.size()), 32'd0);
        end
        if (sa_ena) ena_len++;
        if (!sa_ena && prev_ena) begin
          chk("ena_len", 32'(ena_len), 32'(RUN_CYCLES));
          chk("done_after_ena", 32'(done), 32'd1);
          ena_len = 0;
        end
        prev_we = sa_we;
        prev_ena = sa_ena;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // mode 0: s_valid always high, 1: toggles every cycle, 2: random
  task automatic send_frame(input int mode, input bit rand_data, input int start_beat);
    int k = 0;
    int cyc = 0;
    bit pulsed = 0;
    bit v;
    while (k < FRAME_LEN && cyc < 2000) begin
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      s_valid = v;
      s_data = rand_data ? 8'($urandom_range(0, 255)) : 8'(k + 1);
      start = (k == start_beat) && !pulsed;
      if (start) pulsed = 1'b1;
      @(negedge clk);
      if (v && s_ready) begin
        exp_q.push_back(model_write(k, s_data));
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    start = 1'b0;
    if (k < FRAME_LEN) begin
      chk("send_timeout", 32'(k), 32'(FRAME_LEN));
    end else begin
      @(negedge clk);
      chk("ready_after_last", 32'(s_ready), 32'd0);
    end
  endtask

  task automatic wait_done(input int exp_lat);
    int lat = 0;
    @(negedge clk);
    chk("clr_pulse", 32'(sa_rst), 32'd1);
    @(negedge clk);
    lat = 1;
    chk("clr_one_cycle", 32'(sa_rst), 32'd0);
    chk("ready_after_clr", 32'(s_ready), 32'd1);
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      chk("done_timeout", 32'(done), 32'd1);
    end else begin
      if (exp_lat >= 0) chk("start_to_done", 32'(lat), 32'(exp_lat));
      @(negedge clk);
      chk("done_width", 32'(done), 32'd0);
    end
  endtask

  task automatic start_during_run();
    int g = 0;
    while (!sa_ena && g < 500) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input int mode, input bit rand_data, input int start_beat,
                           input int exp_lat, input bit start_in_run);
    int d0, c0;
    d0 = done_cnt;
    c0 = clr_cycles;
    pulse_start();
    fork
      send_frame(mode, rand_data, start_beat);
      wait_done(exp_lat);
      if (start_in_run) start_during_run();
    join
    repeat (3) @(negedge clk);
    chk("idle_after_frame", 32'(busy), 32'd0);
    chk("one_done_per_frame", 32'(done_cnt - d0), 32'd1);
    chk("one_clr_per_frame", 32'(clr_cycles - c0), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cnt, guard, d0;

    // Reset held with random inputs.
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
      s_valid = 1'($urandom_range(0, 1));
      s_data = 8'($urandom_range(0, 255));
      @(negedge clk);
      chk("reset_sa_rst", 32'(sa_rst), 32'd1);
      chk("reset_outputs", 32'({s_ready, busy, done, sa_we, sa_ena, sa_sel, sa_addr, sa_data}), 32'd0);
    end
    start = 1'b0; s_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk("sa_rst_before_edge", 32'(sa_rst), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("sa_rst_release", 32'(sa_rst), 32'd0);
    chk("busy_release", 32'(busy), 32'd0);

    // Full-rate frame with counting bytes.
    run_frame(0, 1'b0, -1, 1 + FRAME_LEN + RUN_CYCLES + 1, 1'b0);
    // Same frame with s_valid toggling.
    run_frame(1, 1'b0, -1, -1, 1'b0);
    // start pulsed during feature load and during the run window.
    run_frame(0, 1'b0, 20, 1 + FRAME_LEN + RUN_CYCLES + 1, 1'b1);

    // Reset on the 10th enable cycle.
    d0 = done_cnt;
    pulse_start();
    send_frame(0, 1'b1, -1);
    cnt = 0; guard = 0;
    while (cnt < 10 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (sa_ena) cnt++;
    end
    chk("ena_reached_10", 32'(cnt), 32'd10);
    #2 rst = 1'b0;
    #1;
    chk("midrun_ena_off", 32'(sa_ena), 32'd0);
    chk("midrun_sa_rst", 32'(sa_rst), 32'd1);
    chk("midrun_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midrun_release", 32'(sa_rst), 32'd0);
    chk("no_done_after_abort", 32'(done_cnt - d0), 32'd0);

    // Clean frame after abort, then random traffic.
    run_frame(0, 1'b1, -1, 1 + FRAME_LEN + RUN_CYCLES + 1, 1'b0);
    run_frame(2, 1'b1, -1, -1, 1'b0);
    run_frame(2, 1'b1, -1, -1, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
